sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SRAM access cycles per transaction (legal range 1..15).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port i_req  input  1  instruction-port read request (level, held until i_ack).
REQ-005 Port i_addr  input  32  instruction-port address.
REQ-006 Port i_rdata  output  32  instruction-port read data, registered.
REQ-007 Port i_ack  output  1  instruction-port completion, one-cycle pulse.
REQ-008 Port d_req  input  1  data-port request (level, held until d_ack).
REQ-009 Port d_we  input  1  data-port direction: 1 = write, 0 = read.
REQ-010 Port d_addr  input  32  data-port address.
REQ-011 Port d_wdata  input  32  data-port write data.
REQ-012 Port d_rdata  output  32  data-port read data, registered.
REQ-013 Port d_ack  output  1  data-port completion, one-cycle pulse.
REQ-014 Ports mem_cs, mem_oe, mem_we  output  1 each  SRAM chip select, output enable, write enable.
REQ-015 Ports mem_addr, mem_din  output  32 each  SRAM address and write data, registered.
REQ-016 Port mem_dout  input  32  SRAM read data.
REQ-017 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, ACK; all outputs driven from registers.
REQ-019 IDLE: request sampled at clock edge; if any req high, grant one, latch addr/wdata/we of winner, load wait counter WAIT_CYCLES-1, go ACCESS; else stay IDLE.
REQ-020 Arbitration: single requester wins; both requesting -> port not granted last time wins (round-robin via last_grant flag, updated on each grant).
REQ-021 Instruction port SHALL only read: mem_oe=1, mem_we=0 for its grants.
REQ-022 ACCESS: mem_cs=1; mem_oe=~we_latched, mem_we=we_latched; mem_addr/mem_din hold latched values for all WAIT_CYCLES cycles; counter decrements each cycle.
REQ-023 At counter==0 edge in ACCESS: for a read, capture mem_dout into winner's rdata register; go ACK.
REQ-024 ACK: mem_cs/mem_oe/mem_we=0; winner's ack=1 for exactly this cycle; next state IDLE unconditionally.
REQ-025 Latency: request high in IDLE cycle 0 -> ACCESS cycles 1..WAIT_CYCLES -> ack in cycle WAIT_CYCLES+1; next grant earliest cycle WAIT_CYCLES+2.
REQ-026 Non-winner's rdata and ack SHALL be unchanged/low; writes SHALL NOT modify d_rdata.
REQ-027 req high in the IDLE cycle after ack is a new request; requester drops req on ack to avoid re-issue.
REQ-028 Inputs changing after grant SHALL be ignored; req withdrawn mid-access -> transaction still completes and acks.
REQ-029 Losing requester SHALL keep waiting; it is granted in the next IDLE cycle (no starvation: max wait one transaction).
REQ-030 mem_cs, mem_oe, mem_we SHALL never be high outside ACCESS; mem_oe and mem_we never both high.

Reset
REQ-031 rst high SHALL immediately force IDLE, counter 0, mem_cs/oe/we 0, mem_addr/mem_din 0, i_rdata/d_rdata 0, i_ack/d_ack 0, busy 0.
REQ-032 last_grant SHALL reset to data, so first contention after reset grants instruction port.
REQ-033 Reset during ACCESS or ACK aborts the transaction: no ack, no rdata update; requests re-evaluated in first IDLE cycle after rst release.

Verification
REQ-034 Single read, WAIT_CYCLES=2: i_req, i_addr=0x00400000, SRAM returns 0x8C080004 -> mem_cs/oe high cycles 1-2, i_ack cycle 3, i_rdata=0x8C080004.
REQ-035 Data write: d_req, d_we=1, d_addr=0x10000004, d_wdata=0xDEADBEEF -> mem_we high 2 cycles with those addr/din, d_ack cycle 3, d_rdata unchanged.
REQ-036 Contention after reset: i_req and d_req held high -> grants I, D, I, D; acks in cycles 3, 7, 11, 15.
REQ-037 Reset asserted in cycle 1 of ACCESS -> strobes drop asynchronously, no ack, rdata 0; after release pending req served with full latency.
REQ-038 WAIT_CYCLES=1 and 4 builds: ack at cycle 2 and 5 respectively; strobe width equals WAIT_CYCLES; mem_oe and mem_we never overlap.

Source files
------------

// File: rtl/sram_arbiter.sv
// Purpose: round-robin arbiter between an instruction read port and a data read/write port
//          sharing one single-ported SRAM with a fixed access time of WAIT_CYCLES.
// Latency: request sampled in IDLE cycle 0, SRAM strobes in cycles 1..WAIT_CYCLES, ack in cycle WAIT_CYCLES+1.
// Backpressure: a requester holds its req level until its one-cycle ack; the loser simply keeps waiting.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   i_req/i_addr/i_rdata/i_ack  instruction port (read only)
//   d_req/d_we/d_addr/d_wdata   data port request side
//   d_rdata/d_ack               data port response side
//   mem_cs/mem_oe/mem_we        SRAM strobes, high only while accessing
//   mem_addr/mem_din/mem_dout   SRAM address, write data, read data
//   busy                        high whenever a transaction is in progress
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_cs,
  output logic        mem_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_d_q, last_d_d;   // 1: the data port received the most recent grant
  logic        gnt_d_q, gnt_d_d;     // 1: the transaction in flight belongs to the data port
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        cs_q, cs_d;
  logic        oe_q, oe_d;
  logic        mwe_q, mwe_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic        busy_q, busy_d;
  logic        sel_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d_d  = last_d_q;
    gnt_d_d   = gnt_d_q;
    we_d      = we_q;
    addr_d    = addr_q;
    din_d     = din_q;
    cs_d      = cs_q;
    oe_d      = oe_q;
    mwe_d     = mwe_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    // Data wins when alone, or when both ask and the instruction port was served last.
    sel_data  = d_req & (~i_req | ~last_d_q);

    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          gnt_d_d  = sel_data;
          last_d_d = sel_data;
          we_d     = sel_data ? d_we : 1'b0;
          addr_d   = sel_data ? d_addr : i_addr;
          din_d    = sel_data ? d_wdata : 32'd0;
          cnt_d    = CNT_LOAD;
          // Strobes are set on the grant edge so they are registered for every ACCESS cycle.
          cs_d     = 1'b1;
          oe_d     = sel_data ? ~d_we : 1'b1;
          mwe_d    = sel_data ? d_we : 1'b0;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          cs_d    = 1'b0;
          oe_d    = 1'b0;
          mwe_d   = 1'b0;
          state_d = ACK;
          if (!we_q) begin
            if (gnt_d_q) d_rdata_d = mem_dout;
            else         i_rdata_d = mem_dout;
          end
          if (gnt_d_q) d_ack_d = 1'b1;
          else         i_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cs_d    = 1'b0;
        oe_d    = 1'b0;
        mwe_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      last_d_q  <= 1'b1;  // first contention after reset goes to the instruction port
      gnt_d_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      din_q     <= 32'd0;
      cs_q      <= 1'b0;
      oe_q      <= 1'b0;
      mwe_q     <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_d_q  <= last_d_d;
      gnt_d_q   <= gnt_d_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      cs_q      <= cs_d;
      oe_q      <= oe_d;
      mwe_q     <= mwe_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign i_rdata  = i_rdata_q;
  assign i_ack    = i_ack_q;
  assign d_rdata  = d_rdata_q;
  assign d_ack    = d_ack_q;
  assign mem_cs   = cs_q;
  assign mem_oe   = oe_q;
  assign mem_we   = mwe_q;
  assign mem_addr = addr_q;
  assign mem_din  = din_q;
  assign busy     = busy_q;

endmodule
